// File: rtl/equal_search.sv
// equal_search: linear search for a 4-bit target over candidates 0..limit.
// One candidate is compared per SEARCH cycle. The search stops on the first
// match, or on a miss once the candidate reaches the latched limit. The
// found/result/steps outputs hold the outcome until the next accepted start.
module equal_search (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] target,
    input  logic [3:0] limit,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [3:0] result,
    output logic [4:0] steps
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cand;
    logic [3:0] tgt_q;
    logic [3:0] lim_q;
    logic       match;

    // Equality as an AND-reduced bitwise XNOR of candidate and latched target
    assign match = &(cand ~^ tgt_q);

    // Status flags come straight from the registered state, so exactly one is high
    assign ready = (state == IDLE);
    assign busy  = (state == SEARCH);
    assign done  = (state == DONE);

    // Search controller; the match test is checked before the limit test so that
    // target == limit reports a hit, and cand only advances while below lim_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cand   <= 4'd0;
            tgt_q  <= 4'd0;
            lim_q  <= 4'd0;
            found  <= 1'b0;
            result <= 4'd0;
            steps  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q  <= target;
                        lim_q  <= limit;
                        cand   <= 4'd0;
                        found  <= 1'b0;
                        result <= 4'd0;
                        steps  <= 5'd0;
                        state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    steps <= steps + 5'd1;
                    if (match) begin
                        found  <= 1'b1;
                        result <= cand;
                        state  <= DONE;
                    end else if (cand == lim_q) begin
                        found  <= 1'b0;
                        result <= lim_q;
                        state  <= DONE;
                    end else begin
                        cand <= cand + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_equal_search.sv
// Bench for equal_search: directed table of searches, hand-written reset and
// start-dropping sequences, and random searches against a reference model.
module tb_equal_search;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] target;
    logic [3:0] limit;
    logic       ready;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] result;
    logic [4:0] steps;

    int vectors;
    int miscompares;

    equal_search dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .target (target),
        .limit  (limit),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .steps  (steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] t;
        logic [3:0] l;
        bit         pulse;
        logic [3:0] t2;
        bit         f;
        logic [3:0] r;
        logic [4:0] s;
        int         cyc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk candidates 0..limit, stop at the first one equal to target
    task automatic ref_search(input int t, input int l, output bit f, output int r,
                              output int s);
        f = 1'b0;
        r = l;
        s = 0;
        for (int c = 0; c <= l; c++) begin
            s++;
            if (c == t) begin
                f = 1'b1;
                r = c;
                break;
            end
        end
    endtask

    // Launch one search from IDLE, optionally disturb inputs mid-search and/or
    // hold start during DONE, then check latency, outcome and return to IDLE.
    task automatic run_search(input string tag, input logic [3:0] t, input logic [3:0] l,
                              input bit pulse, input logic [3:0] t2, input bit start_in_done,
                              input bit exp_f, input int exp_r, input int exp_s,
                              input int exp_cyc);
        int  k;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        start  = 1'b1;
        target = t;
        limit  = l;
        @(negedge clk);
        start  = 1'b0;
        check({tag, " accepted_busy"}, busy, 1);
        check({tag, " cleared_steps"}, steps, 0);
        seen    = 1'b0;
        busy_ok = 1'b1;
        k       = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy || ready) busy_ok = 1'b0;
                if (pulse && k == 2) begin
                    start  = 1'b1;
                    target = t2;
                    limit  = 4'd1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, seen, 1);
        check({tag, " done_edge"}, k, exp_cyc);
        check({tag, " busy_until_done"}, busy_ok, 1);
        check({tag, " found"}, found, exp_f);
        check({tag, " result"}, result, exp_r);
        check({tag, " steps"}, steps, exp_s);
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " ready_after"}, ready, 1);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " not_restarted"}, busy, 0);
        check({tag, " result_held"}, result, exp_r);
    endtask

    vec_t vecs[7];

    initial begin
        bit rf;
        int rr;
        int rs;
        logic [3:0] rt;
        logic [3:0] rl;
        vectors     = 0;
        miscompares = 0;
        start  = 1'b0;
        target = 4'd0;
        limit  = 4'd0;
        reset  = 1'b1;

        vecs[0] = '{4'd5,  4'd15, 1'b0, 4'd0, 1'b1, 4'd5,  5'd6,  6};
        vecs[1] = '{4'd9,  4'd3,  1'b0, 4'd0, 1'b0, 4'd3,  5'd4,  4};
        vecs[2] = '{4'd0,  4'd0,  1'b0, 4'd0, 1'b1, 4'd0,  5'd1,  1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0, 1'b1, 4'd15, 5'd16, 16};
        vecs[4] = '{4'd12, 4'd15, 1'b1, 4'd2, 1'b1, 4'd12, 5'd13, 13};
        vecs[5] = '{4'd7,  4'd7,  1'b0, 4'd0, 1'b1, 4'd7,  5'd8,  8};
        vecs[6] = '{4'd3,  4'd0,  1'b0, 4'd0, 1'b0, 4'd0,  5'd1,  1};

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset with no start
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle ready", ready, 1);
            check("idle busy", busy, 0);
            check("idle done", done, 0);
            check("idle found", found, 0);
            check("idle result", result, 0);
            check("idle steps", steps, 0);
        end

        // Directed table; the 0/0 entry also holds start through its DONE cycle
        for (int i = 0; i < 7; i++) begin
            run_search($sformatf("vec%0d", i), vecs[i].t, vecs[i].l, vecs[i].pulse,
                       vecs[i].t2, (i == 2), vecs[i].f, vecs[i].r, vecs[i].s, vecs[i].cyc);
        end

        // Reset mid-search: outputs clear asynchronously, no done pulse follows
        @(negedge clk);
        start  = 1'b1;
        target = 4'd10;
        limit  = 4'd15;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst ready", ready, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst found", found, 0);
        check("rst result", result, 0);
        check("rst steps", steps, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            bit pulsed;
            pulsed = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done || busy) pulsed = 1'b1;
            end
            check("rst no_done_after_abort", pulsed, 0);
        end
        run_search("post_rst", 4'd1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1, 2, 2);

        // Random searches against the reference model
        for (int n = 0; n < 40; n++) begin
            rt = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            ref_search(int'(rt), int'(rl), rf, rr, rs);
            run_search($sformatf("rnd%0d t=%0d l=%0d", n, rt, rl), rt, rl,
                       ($urandom_range(0, 3) == 0) && (rs > 3), 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 1) == 1), rf, rr, rs, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/equal_search.md
EQUAL_SEARCH -- requirements
Module: equal_search

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk     input   1  single clock; all state updates on its rising edge
- reset   input   1  asynchronous, active-high; clears all state immediately
- start   input   1  request a new search; sampled only in IDLE
- target  input   4  value to find; sampled with start
- limit   input   4  highest candidate to try (inclusive); sampled with start
- ready   output  1  high in IDLE
- busy    output  1  high in SEARCH
- done    output  1  one-cycle pulse, high in DONE
- found   output  1  last search matched; held until next accepted start
- result  output  4  matched candidate, or the latched limit on miss; held until next accepted start
- steps   output  5  comparisons made by last search, 1..16; held until next accepted start
REQ-002 There SHALL be no parameters; all widths are fixed as listed above.

Function
REQ-003 The module SHALL implement a three-state FSM: IDLE, SEARCH, DONE.
REQ-004 IDLE with start=1 at a rising edge: latch target to tgt_q and limit to lim_q, set cand=0, clear found, result and steps, go to SEARCH.
REQ-005 IDLE with start=0 SHALL hold all state.
REQ-006 start SHALL be ignored in SEARCH and DONE; target and limit changes after acceptance SHALL NOT affect a running search.
REQ-007 Each SEARCH cycle SHALL compare cand to tgt_q using bitwise XNOR of all 4 bits reduced by AND, and SHALL increment steps.
REQ-008 SEARCH on match: found=1, result=cand, go to DONE; the match check SHALL take priority over the limit check.
REQ-009 SEARCH on no match with cand==lim_q: found=0, result=lim_q, go to DONE.
REQ-010 SEARCH otherwise: cand=cand+1 and stay in SEARCH; cand SHALL never wrap, because the limit check ends the search at cand=15 at the latest.
REQ-011 DONE SHALL last exactly one cycle, then return to IDLE; a start in that cycle SHALL be dropped.
REQ-012 If the search ends on a match, done SHALL rise at the (tgt_q+1)th rising edge after the accepting edge, with steps=tgt_q+1.
REQ-013 If the search ends on a miss (tgt_q>lim_q), done SHALL rise at the (lim_q+1)th rising edge after the accepting edge, with steps=lim_q+1.
REQ-014 ready, busy and done SHALL be decoded from the registered state only; exactly one SHALL be high at any time.
REQ-015 limit=0 SHALL perform exactly one comparison (cand=0).
REQ-016 target=limit SHALL report a match (found=1), per the priority in REQ-008.

Reset
REQ-017 When reset=1, asynchronously and regardless of clk, the module SHALL force: state=IDLE, cand=0, tgt_q=0, lim_q=0, found=0, result=0, steps=0; hence ready=1, busy=0, done=0.
REQ-018 Reset asserted mid-SEARCH SHALL abort the search with no done pulse; after release, the first edge with start=1 SHALL start a fresh search.
REQ-019 An output not otherwise written (e.g. found on a miss) SHALL keep its reset or cleared value.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset released, start=0 for 5 cycles -> ready=1, busy=0, done=0, found=0, result=0, steps=0 throughout.
- start with target=5, limit=15 -> busy for 6 cycles; done pulse at edge 6 after acceptance; found=1, result=5, steps=6; ready=1 next cycle.
- start with target=9, limit=3 -> done at edge 4; found=0, result=3, steps=4.
- start with target=0, limit=0, then target=15, limit=15 -> first: done at edge 1, found=1, result=0, steps=1; second: found=1, result=15, steps=16, no wrap of cand.
- start with target=12, limit=15; change target to 2 and pulse start during SEARCH -> change ignored; found=1, result=12, steps=13.
- start with target=10, limit=15; assert reset at edge 4 -> outputs cleared immediately, no done pulse; after release, a new start with target=1 gives found=1, result=1, steps=2.
